// File: rtl/wb_scoreboard_pkg.sv
// Shared types for the writeback scoreboard: source encoding, write-port
// record and the round-robin pick helper.
package wb_scoreboard_pkg;

    localparam int NUM_WB_SRC = 4;
    localparam int WB_XLEN    = 32;
    localparam int WB_AW      = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MUL = 2'd1,
        WB_DIV = 2'd2,
        WB_LSU = 2'd3
    } wb_src_e;

    // Registered register-file write port. Sized by the package constants,
    // which match the default XLEN / NUM_REGS of the top.
    typedef struct packed {
        logic               wr_en;
        logic [WB_AW-1:0]   rd_addr;
        logic [WB_XLEN-1:0] data;
    } wb_port_t;

    // One-hot pick of the first set bit of mask, searching from ptr upward
    // and wrapping over the three multi-cycle sources (0=MUL,1=DIV,2=LSU).
    function automatic logic [2:0] rr_pick(input logic [2:0] mask, input logic [1:0] ptr);
        logic [2:0] g;
        logic [2:0] s;
        g = '0;
        // Walk from farthest to nearest so the nearest match is the last write.
        for (int k = 2; k >= 0; k--) begin
            s = {1'b0, ptr} + 3'(k);
            if (s >= 3'd3) s = s - 3'd3;
            if (mask[s[1:0]]) g = 3'b001 << s[1:0];
        end
        return g;
    endfunction

endpackage

// File: rtl/wb_scoreboard_rr_arbiter.sv
// Writeback arbiter: fixed ALU priority, round-robin among MUL/DIV/LSU and a
// starvation guard that lets a long-denied multi-cycle source preempt the ALU.
module wb_rr_arbiter
    import wb_scoreboard_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_WB_SRC-1:0] req,
    output logic [NUM_WB_SRC-1:0] gnt,
    output logic                  starve_block
);

    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q [3];
    logic [3:0] cnt_d [3];
    logic [2:0] starve_mask;
    logic [2:0] mc_gnt;

    // Which multi-cycle sources have waited too long.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            starve_mask[i] = (cnt_q[i] >= 4'(STARVE_LIMIT));
        end
        starve_block = |starve_mask;
    end

    // Grant selection; nothing is granted while reset is held so held requests
    // are arbitrated afresh once reset drops.
    always_comb begin
        gnt    = '0;
        mc_gnt = '0;
        if (!rst) begin
            if (starve_block) begin
                mc_gnt = rr_pick(starve_mask & req[3:1], ptr_q);
            end else if (req[WB_ALU]) begin
                gnt[WB_ALU] = 1'b1;
            end else begin
                mc_gnt = rr_pick(req[3:1], ptr_q);
            end
            gnt[3:1] = mc_gnt;
        end
    end

    // Pointer advance past the granted source and per-source wait counters.
    always_comb begin
        ptr_d = ptr_q;
        if (mc_gnt[0])      ptr_d = 2'd1;
        else if (mc_gnt[1]) ptr_d = 2'd2;
        else if (mc_gnt[2]) ptr_d = 2'd0;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!req[i+1] || mc_gnt[i]) cnt_d[i] = '0;
            else if (cnt_q[i] != 4'd15)  cnt_d[i] = cnt_q[i] + 4'd1;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Register-busy scoreboard and single write-port owner between issue and
// the execution units. Stalls issue on RAW/WAW against pending registers.
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int XLEN         = WB_XLEN,
    parameter int NUM_REGS     = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic                       issue_rs1_en,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rs1_addr,
    input  logic                       issue_rs2_en,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rs2_addr,
    input  logic                       issue_rd_en,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rd_addr,
    input  logic                       issue_fire,
    output logic                       hazard_stall,
    input  logic [NUM_WB_SRC-1:0]      wb_req,
    input  logic [NUM_WB_SRC*$clog2(NUM_REGS)-1:0] wb_rd_addr,
    input  logic [NUM_WB_SRC*XLEN-1:0] wb_data,
    output logic [NUM_WB_SRC-1:0]      wb_gnt,
    output logic                       rf_wr_en,
    output logic [$clog2(NUM_REGS)-1:0] rf_wr_addr,
    output logic [XLEN-1:0]            rf_wr_data
);

    localparam int AW = $clog2(NUM_REGS);

    // Handshakes: a writeback source holds wb_req, its rd and data stable
    // until wb_gnt; the transfer is the cycle where req & gnt. Issue fires
    // only when hazard_stall is low.

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] clr_vec, busy_vec;
    wb_port_t            port_q, port_d;
    logic                starve_block;

    wb_rr_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (wb_req),
        .gnt          (wb_gnt),
        .starve_block (starve_block)
    );

    // A register being written this cycle is forwarded by the reg file, so
    // it no longer counts as busy.
    always_comb begin
        clr_vec = '0;
        if (port_q.wr_en) clr_vec[port_q.rd_addr] = 1'b1;
        busy_vec = pending_q & ~clr_vec;
        hazard_stall = starve_block |
            (issue_valid & ((issue_rs1_en & busy_vec[issue_rs1_addr]) |
                            (issue_rs2_en & busy_vec[issue_rs2_addr]) |
                            (issue_rd_en  & busy_vec[issue_rd_addr])));
    end

    // Scoreboard update: clear on writeback, then set on issue so set wins.
    always_comb begin
        pending_d = pending_q & ~clr_vec;
        if (issue_fire && !hazard_stall && issue_rd_en && issue_rd_addr != '0)
            pending_d[issue_rd_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Next write-port contents: load from the granted source; x0 completes
    // the handshake without writing.
    always_comb begin
        port_d       = port_q;
        port_d.wr_en = 1'b0;
        for (int i = 0; i < NUM_WB_SRC; i++) begin
            if (wb_gnt[i]) begin
                port_d.rd_addr = wb_rd_addr[i*AW +: AW];
                port_d.data    = wb_data[i*XLEN +: XLEN];
                port_d.wr_en   = (wb_rd_addr[i*AW +: AW] != '0);
            end
        end
    end

    // Scoreboard and write-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            port_q    <= '0;
        end else begin
            pending_q <= pending_d;
            port_q    <= port_d;
        end
    end

    assign rf_wr_en   = port_q.wr_en;
    assign rf_wr_addr = port_q.rd_addr;
    assign rf_wr_data = port_q.data;

`ifndef SYNTHESIS
    issue_fire_legal: assert property (@(posedge clk) disable iff (rst)
        !(issue_fire && hazard_stall));
`endif

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Owns the single register-file write port and the register-busy scoreboard between the issue stage and the execution units.
- Tracks destination registers of issued instructions until their result is written back, and stalls issue on RAW or WAW hazards against those registers.
- Arbitrates the write port among the ALU, MUL, DIV and LSU result sources: fixed ALU priority, round-robin among the multi-cycle units, and a starvation guard.
- Its registered write-port outputs drive the reg file write port and the exu_wb_* forwarding paths.

Parameters:
- XLEN, 32, data width.
- NUM_REGS, 32, architectural registers; address width is $clog2(NUM_REGS).
- STARVE_LIMIT, 4, consecutive denied cycles after which a multi-cycle source preempts the ALU. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  legal non-nop instruction presented for issue
- issue_rs1_en  in  1  rs1 is read
- issue_rs1_addr  in  5  rs1 index
- issue_rs2_en  in  1  rs2 is read
- issue_rs2_addr  in  5  rs2 index
- issue_rd_en  in  1  instruction writes rd
- issue_rd_addr  in  5  rd index
- issue_fire  in  1  instruction accepted by EXU this cycle
- hazard_stall  out  1  issue must not fire; combinational
- wb_req  in  4  per-source writeback request; bit0 ALU, bit1 MUL, bit2 DIV, bit3 LSU
- wb_rd_addr  in  20  per-source rd index, packed 4x5
- wb_data  in  4*XLEN  per-source result, packed
- wb_gnt  out  4  one-hot grant; combinational
- rf_wr_en  out  1  registered reg-file write enable
- rf_wr_addr  out  5  registered write address
- rf_wr_data  out  XLEN  registered write data

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - pending[] all 0.
  - Round-robin pointer = MUL.
  - Wait counters 0; starve flag 0.
  - rf_wr_en 0, rf_wr_addr 0, rf_wr_data 0.
  - Reset mid-operation drops all in-flight state; outstanding requests are re-arbitrated after reset.
- Scoreboard:
  - Bit pending[r] is set on issue_fire & issue_rd_en & (issue_rd_addr != 0).
  - pending[r] is cleared in the cycle rf_wr_en=1 with rf_wr_addr=r.
  - Set and clear of the same r in one cycle: set wins.
  - pending[0] is constant 0.
- Hazard: let busy(r) = pending[r] & ~(rf_wr_en & rf_wr_addr==r). The write-back-cycle case is covered by reg file forwarding. hazard_stall is asserted when either holds:
  - issue_valid & ((rs1_en & busy(rs1)) | (rs2_en & busy(rs2)) | (rd_en & busy(rd))), where busy(rd) is the WAW check;
  - starve_block (below).
  - hazard_stall is 0 when issue_valid=0 and no starvation is active.
- issue_fire while hazard_stall=1 is a protocol violation: no scoreboard update; simulation assertion fires.
- Arbitration handshake: a source holds wb_req, rd_addr and data stable until wb_gnt. Transfer happens in the cycle req & gnt.
- Grant selection, at most one grant per cycle:
  - If starve_block: grant the starving source with the highest priority from the round-robin pointer.
  - Else if wb_req[0]: grant ALU.
  - Else: round-robin over MUL, DIV, LSU starting at the pointer.
- After a MUL/DIV/LSU grant, the pointer moves to the granted source + 1, wrapping LSU→MUL. ALU grants do not move the pointer.
- Wait counters:
  - Per multi-cycle source: increment while req & ~gnt, saturating at 15.
  - Clear on grant or when req drops.
  - starve_block = any counter >= STARVE_LIMIT. It holds the ALU off the port and stalls issue until that source is granted.
- Write port: on any grant, next cycle rf_wr_en = 1 & (granted rd != 0), with rf_wr_addr and rf_wr_data taken from the granted source.
  - rd = 0 grants complete the handshake and clear nothing.
  - Latency: 1 cycle from grant to write.
  - No grant → rf_wr_en=0; addr and data hold their previous values.

Decomposition:
- Shared package:
  - wb_src_e enum: WB_ALU=0, WB_MUL=1, WB_DIV=2, WB_LSU=3.
  - NUM_WB_SRC=4.
  - wb_port_t struct {wr_en, rd_addr, data} for the registered write port.
- One sub-module, wb_rr_arbiter: 3-way round-robin with pointer register and starvation counters, parameterised by STARVE_LIMIT.

Test Plan:
- Issue rd=x5 (MUL); next cycle issue with rs1=x5 → hazard_stall=1 until MUL is granted. In the rf_wr_en cycle for x5, stall drops and the dependent issue_fire succeeds.
- Issue rd=x7 (DIV), then issue with rd=x7 → WAW stall. Write back x7 with same-cycle reissue to x7 → pending[7] stays 1 (set wins).
- MUL, DIV and LSU request continuously with no ALU → grants rotate MUL,DIV,LSU,MUL… one per cycle; rf_wr_* follows one cycle later.
- ALU requests every cycle while LSU requests, STARVE_LIMIT=4 → LSU denied 4 cycles, then hazard_stall=1 and the 5th-cycle grant goes to LSU with ALU gnt=0. ALU is granted the next cycle.
- Grant with rd=x0 and data 0xDEADBEEF → wb_gnt pulses, rf_wr_en stays 0, no pending change. Issuing rd=x0 never stalls.
- Assert rst with pending bits set and requests waiting → next cycle pending cleared, rf_wr_en=0, pointer=MUL; held requests are granted in RR order after reset.
